// File: rtl/scene_recovery_if.sv
// rtl/scene_recovery_if.sv - pixel/transmission input and recovered-pixel output handshake bundle
interface scene_recovery_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_r;
   logic [7:0]  in_g;
   logic [7:0]  in_b;
   logic [15:0] in_t;
   logic [7:0]  atm_r;
   logic [7:0]  atm_g;
   logic [7:0]  atm_b;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_r;
   logic [7:0]  out_g;
   logic [7:0]  out_b;

   modport master (
      output in_valid, in_r, in_g, in_b, in_t, atm_r, atm_g, atm_b, out_ready,
      input  in_ready, out_valid, out_r, out_g, out_b
   );

   modport slave (
      input  in_valid, in_r, in_g, in_b, in_t, atm_r, atm_g, atm_b, out_ready,
      output in_ready, out_valid, out_r, out_g, out_b
   );
endinterface

// File: rtl/scene_recovery.sv
// rtl/scene_recovery.sv - dehaze recovery J = A + (I - A)/t with serial reciprocal divider
module scene_recovery #(
   parameter logic [15:0] T0         = 16'd21299,
   parameter int          DIV_CYCLES = 16
) (
   input logic             clk,
   input logic             rst,
   scene_recovery_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DIV, CALC, OUT} state_t;

   state_t      state, state_nxt;
   logic [7:0]  i_r, i_g, i_b;
   logic [7:0]  a_r, a_g, a_b;
   logic [15:0] t_eff;
   logic [15:0] quo;
   logic [16:0] rem;
   logic [4:0]  cnt;
   logic [7:0]  res_r, res_g, res_b;

   logic [16:0] rem_sh;
   logic [16:0] rem_nxt;
   logic        div_bit;
   logic        last_iter;

   // One quotient bit of 2^30 / t_eff per cycle; remainder never exceeds t_eff.
   always_comb begin
      rem_sh    = {rem[15:0], 1'b0};
      div_bit   = (rem_sh >= {1'b0, t_eff});
      rem_nxt   = div_bit ? (rem_sh - {1'b0, t_eff}) : rem_sh;
      last_iter = (cnt == 5'(DIV_CYCLES - 1));
   end

   function automatic logic [7:0] recover(input logic [7:0] i, input logic [7:0] a,
                                          input logic [15:0] q);
      logic signed [8:0]  d;
      logic signed [25:0] d_ext;
      logic signed [25:0] q_ext;
      logic signed [25:0] p;
      logic signed [25:0] r;
      logic signed [26:0] s;
      d     = $signed({1'b0, i}) - $signed({1'b0, a});
      d_ext = 26'(d);
      q_ext = $signed({10'd0, q});
      p     = d_ext * q_ext;
      r     = (p + 26'sd8192) >>> 14;
      s     = 27'(r) + $signed({19'd0, a});
      if (s < 27'sd0) begin
         recover = 8'd0;
      end else if (s > 27'sd255) begin
         recover = 8'd255;
      end else begin
         recover = s[7:0];
      end
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.in_valid) state_nxt = DIV;
         DIV:  if (last_iter) state_nxt = CALC;
         CALC: state_nxt = OUT;
         OUT:  if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_r   <= 8'd0;
         i_g   <= 8'd0;
         i_b   <= 8'd0;
         a_r   <= 8'd0;
         a_g   <= 8'd0;
         a_b   <= 8'd0;
         t_eff <= 16'd0;
         quo   <= 16'd0;
         rem   <= 17'd0;
         cnt   <= 5'd0;
         res_r <= 8'd0;
         res_g <= 8'd0;
         res_b <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  i_r   <= bus.in_r;
                  i_g   <= bus.in_g;
                  i_b   <= bus.in_b;
                  a_r   <= bus.atm_r;
                  a_g   <= bus.atm_g;
                  a_b   <= bus.atm_b;
                  t_eff <= (bus.in_t < T0) ? T0 : bus.in_t;
                  rem   <= 17'd16384;
                  quo   <= 16'd0;
                  cnt   <= 5'd0;
               end
            end
            DIV: begin
               rem <= rem_nxt;
               quo <= {quo[14:0], div_bit};
               cnt <= cnt + 5'd1;
            end
            CALC: begin
               res_r <= recover(i_r, a_r, quo);
               res_g <= recover(i_g, a_g, quo);
               res_b <= recover(i_b, a_b, quo);
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == OUT);
   assign bus.out_r     = res_r;
   assign bus.out_g     = res_g;
   assign bus.out_b     = res_b;

endmodule

// File: tb/tb_scene_recovery.sv
// tb/tb_scene_recovery.sv - self-checking bench for scene_recovery
module tb_scene_recovery;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scene_recovery_if bus();

   scene_recovery dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   typedef struct {
      logic [7:0]  ir, ig, ib;
      logic [15:0] t;
      logic [7:0]  ar, ag, ab;
      logic [7:0]  er, eg, eb;
   } vec_t;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference: J = A + round_half_up((I - A) * floor(2^30 / max(t, T0)) / 2^14), clamped.
   function automatic logic [7:0] model_chan(input int i, input int a, input int t);
      longint teff, q, num, r, s;
      teff = (t < 21299) ? 21299 : t;
      q    = (longint'(1) << 30) / teff;
      num  = longint'(i - a) * q + 8192;
      r    = (num >= 0) ? num / 16384 : -((-num + 16383) / 16384);
      s    = a + r;
      if (s < 0) return 8'd0;
      if (s > 255) return 8'd255;
      return s[7:0];
   endfunction

   task automatic drive_vec(input vec_t v);
      bus.in_r  = v.ir;
      bus.in_g  = v.ig;
      bus.in_b  = v.ib;
      bus.in_t  = v.t;
      bus.atm_r = v.ar;
      bus.atm_g = v.ag;
      bus.atm_b = v.ab;
   endtask

   task automatic scramble_inputs();
      bus.in_r  = 8'($urandom);
      bus.in_g  = 8'($urandom);
      bus.in_b  = 8'($urandom);
      bus.in_t  = 16'($urandom);
      bus.atm_r = 8'($urandom);
      bus.atm_g = 8'($urandom);
      bus.atm_b = 8'($urandom);
   endtask

   // Accept one pixel, return its result, latency (cycle of first out_valid) and hold stability.
   task automatic do_pixel(input vec_t v, input int hold,
                           output logic [7:0] r, output logic [7:0] g, output logic [7:0] b,
                           output int lat, output int stable);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("in_ready_wait", int'(guard < 50), 1);
      drive_vec(v);
      bus.out_ready = (hold == 0);
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      scramble_inputs();
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      r = bus.out_r;
      g = bus.out_g;
      b = bus.out_b;
      stable = 1;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if (bus.out_r != r || bus.out_g != g || bus.out_b != b || !bus.out_valid) stable = 0;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   vec_t vecs[6];

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r, g, b, r0, g0, b0;
      int lat, stable, seen;
      vec_t v;

      vecs[0] = '{8'd37,  8'd128, 8'd250, 16'd65535, 8'd100, 8'd100, 8'd100, 8'd37,  8'd128, 8'd250};
      vecs[1] = '{8'd120, 8'd200, 8'd50,  16'd5000,  8'd100, 8'd100, 8'd100, 8'd162, 8'd255, 8'd0};
      vecs[2] = '{8'd120, 8'd200, 8'd50,  16'd21299, 8'd100, 8'd100, 8'd100, 8'd162, 8'd255, 8'd0};
      vecs[3] = '{8'd120, 8'd200, 8'd50,  16'd0,     8'd100, 8'd100, 8'd100, 8'd162, 8'd255, 8'd0};
      vecs[4] = '{8'd0,   8'd255, 8'd128, 16'd32768, 8'd200, 8'd50,  8'd128, 8'd0,   8'd255, 8'd128};
      vecs[5] = '{8'd101, 8'd99,  8'd100, 16'd43690, 8'd100, 8'd100, 8'd100, 8'd102, 8'd99,  8'd100};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive_vec(vecs[0]);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_in_ready", int'(bus.in_ready), 1);
      check("reset_out_valid", int'(bus.out_valid), 0);
      check("reset_out_r", int'(bus.out_r), 0);
      check("reset_out_g", int'(bus.out_g), 0);
      check("reset_out_b", int'(bus.out_b), 0);

      foreach (vecs[n]) begin
         do_pixel(vecs[n], 0, r, g, b, lat, stable);
         check($sformatf("vec%0d_r", n), int'(r), int'(vecs[n].er));
         check($sformatf("vec%0d_g", n), int'(g), int'(vecs[n].eg));
         check($sformatf("vec%0d_b", n), int'(b), int'(vecs[n].eb));
         check($sformatf("vec%0d_latency", n), lat, 18);
         check($sformatf("vec%0d_valid_drop", n), int'(bus.out_valid), 0);
         check($sformatf("vec%0d_ready_back", n), int'(bus.in_ready), 1);
      end

      // Backpressure: output held for 10 cycles, a second in_valid must be ignored.
      bus.out_ready = 1'b0;
      drive_vec(vecs[1]);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_latency", lat, 18);
      r0 = bus.out_r; g0 = bus.out_g; b0 = bus.out_b;
      stable = 1;
      for (int k = 0; k < 10; k++) begin
         if (k == 3) begin
            drive_vec(vecs[0]);
            bus.in_valid = 1'b1;
         end
         @(posedge clk); #1;
         if (bus.out_r != r0 || bus.out_g != g0 || bus.out_b != b0) stable = 0;
         if (bus.in_ready || !bus.out_valid) stable = 0;
      end
      bus.in_valid = 1'b0;
      check("bp_stable", stable, 1);
      check("bp_out_r", int'(r0), 162);
      check("bp_out_g", int'(g0), 255);
      check("bp_out_b", int'(b0), 0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_drop", int'(bus.out_valid), 0);
      check("bp_ready_back", int'(bus.in_ready), 1);
      check("bp_hold_last", int'(bus.out_r), 162);
      seen = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1;
      end
      check("bp_no_queued_pixel", seen, 0);

      // Reset at cycle 8 after accept discards the pixel in flight.
      drive_vec(vecs[0]);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_in_ready", int'(bus.in_ready), 1);
      check("mid_rst_out_valid", int'(bus.out_valid), 0);
      check("mid_rst_out_cleared", int'(bus.out_r), 0);
      seen = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1;
      end
      check("mid_rst_no_output", seen, 0);
      do_pixel(vecs[1], 0, r, g, b, lat, stable);
      check("post_rst_r", int'(r), 162);
      check("post_rst_g", int'(g), 255);
      check("post_rst_b", int'(b), 0);
      check("post_rst_latency", lat, 18);

      // Randomized pixels against the arithmetic reference, with random backpressure.
      for (int n = 0; n < 40; n++) begin
         int hold;
         v.ir = 8'($urandom); v.ig = 8'($urandom); v.ib = 8'($urandom);
         v.ar = 8'($urandom); v.ag = 8'($urandom); v.ab = 8'($urandom);
         case ($urandom_range(0, 3))
            0:       v.t = 16'($urandom_range(21290, 21310));
            1:       v.t = 16'($urandom_range(0, 21298));
            default: v.t = 16'($urandom);
         endcase
         v.er = model_chan(int'(v.ir), int'(v.ar), int'(v.t));
         v.eg = model_chan(int'(v.ig), int'(v.ag), int'(v.t));
         v.eb = model_chan(int'(v.ib), int'(v.ab), int'(v.t));
         hold = $urandom_range(0, 3);
         do_pixel(v, hold, r, g, b, lat, stable);
         check($sformatf("rnd%0d_r t=%0d", n, v.t), int'(r), int'(v.er));
         check($sformatf("rnd%0d_g t=%0d", n, v.t), int'(g), int'(v.eg));
         check($sformatf("rnd%0d_b t=%0d", n, v.t), int'(b), int'(v.eb));
         check($sformatf("rnd%0d_latency", n), lat, 18);
         check($sformatf("rnd%0d_stable", n), stable, 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/scene_recovery.md
Name: scene_recovery

Overview:
- Final dehaze stage, directly downstream of the transmission estimator.
- Takes a hazy RGB pixel I, its transmission t (Q0.16) and the atmospheric light A.
- Produces the recovered pixel J = A + (I − A)/t per channel.
- Computes 1/t with an iterative restoring divider, then does one multiply/round/saturate cycle. Uses a valid/ready handshake on both sides.

Parameters:
- T0, 21299, lower transmission bound (0.325 in Q0.16). Inputs below T0 are clamped to T0. Must be > 16384.
- DIV_CYCLES, 16, divider iterations, one quotient bit per cycle. Fixed at 16 for correctness.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input pixel, t and A valid
- in_ready  output  1  block can accept an input
- in_r / in_g / in_b  input  8 each  hazy pixel channels
- in_t  input  16  transmission, Q0.16
- atm_r / atm_g / atm_b  input  8 each  atmospheric light per channel
- out_valid  output  1  recovered pixel valid
- out_ready  input  1  downstream accepts the output
- out_r / out_g / out_b  output  8 each  recovered pixel channels

Behaviour:
- **FSM states:** IDLE → DIV → CALC → OUT → IDLE.
- **Reset:**
  - Synchronous; FSM goes to IDLE.
  - in_ready=1, out_valid=0, out_r/g/b=0, divider registers cleared.
  - Reset mid-operation discards the pixel in flight, with no output.
- **IDLE:**
  - in_ready=1.
  - On in_valid=1, register in_r/g/b, atm_r/g/b and T_eff = (in_t < T0) ? T0 : in_t; go to DIV.
  - in_t=0 is covered by the clamp; there is no divide-by-zero.
- **DIV:**
  - in_ready=0.
  - Compute Q = floor(2^30 / T_eff), i.e. 1/t in Q2.14.
  - Restoring division: remainder preloaded with 2^14, 16 iterations, each shifting in one zero dividend bit.
  - Each iteration yields one quotient bit, MSB first.
  - T_eff > 2^14 guarantees Q < 2^16, so Q is 16 bits.
  - After the 16th iteration, go to CALC.
- **CALC (one cycle), per channel c:**
  - D = I_c − A_c, signed 9-bit.
  - P = D × Q, signed 26-bit.
  - R = (P + 8192) >>> 14. Arithmetic shift, i.e. round-half-up then floor.
  - S = A_c + R, signed.
  - out_c = 0 if S < 0; 255 if S > 255; else S[7:0].
  - Register the outputs, go to OUT.
- **OUT:**
  - out_valid=1; out_r/g/b held stable while out_ready=0.
  - On out_ready=1, the transfer completes: out_valid goes to 0 the next cycle and the FSM returns to IDLE.
  - out_r/g/b keep their last value after transfer.
- **Latency:**
  - Accept at cycle 0, DIV on cycles 1–16, CALC on cycle 17, out_valid=1 from cycle 18.
  - Minimum initiation interval is 19 cycles with out_ready tied high. The next in_ready is at cycle 19.
- **No overlap:** in_ready=0 throughout DIV/CALC/OUT. in_valid asserted then is ignored, not queued.
- **Atmospheric light:** A is sampled only on accept; changes to atm_* mid-operation have no effect.

Test Plan:
- **Reset and idle:** rst=1 for 2 cycles, then inputs idle → in_ready=1, out_valid=0, outputs 0.
- **Unity transmission:** in_t=65535, I=(37,128,250), A=(100,100,100) → Q=16384; out=(37,128,250) exactly; out_valid at cycle 18 after accept.
- **Clamp plus rounding and saturation:** in_t=5000 (clamped to 21299), I=(120,200,50), A=(100,100,100).
  - Q=50412.
  - out=(162,255,0): R=62, overflow saturates to 255, R=−154 saturates to 0.
- **in_t at T0:** in_t=21299 → same result as the clamp case; in_t=0 → same result, no X and no hang.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid.
  - Outputs stay stable, in_ready=0, a second in_valid is ignored.
  - Release out_ready → one transfer, then in_ready=1 the next cycle.
- **Reset mid-DIV:** assert rst at cycle 8 after accept → FSM in IDLE next cycle, out_valid never rises. A fresh pixel then yields the correct result.
